// File: rtl/c3po_regs_pkg.sv
// c3po_regs_pkg: register map constants, field positions and FSM state
// type shared by the C-3PO per-port CSR bank.
package c3po_regs_pkg;

  // Register offsets inside a port window
  localparam int CTRL_OFF   = 0;
  localparam int STATUS_OFF = 1;
  localparam int COUNT_OFF  = 2;
  localparam int NUM_REGS   = 3;

  // CTRL field positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_ID_LSB   = 4;
  localparam int CTRL_ERR_BIT  = 8;
  localparam int CTRL_IDLE_BIT = 9;
  localparam int CTRL_MASK_BIT = 12;

  // STATUS field positions
  localparam int STAT_STICKY_BIT = 0;
  localparam int STAT_IDLE_BIT   = 1;

  // Host-side transaction FSM
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_e;

endpackage

// File: rtl/c3po_csr_bank_if.sv
// c3po_csr_bank_if: registered req/ack host configuration bus.
interface c3po_csr_bank_if #(
  parameter int ADDR_SIZE_P = 8
);
  logic [ADDR_SIZE_P-1:0] addr;
  logic                   rd_wr;
  logic                   req;
  logic [31:0]            write_val;
  logic [31:0]            read_val;
  logic                   ack;
  logic                   resp_err;

  modport master (
    output addr, rd_wr, req, write_val,
    input  read_val, ack, resp_err
  );

  modport slave (
    input  addr, rd_wr, req, write_val,
    output read_val, ack, resp_err
  );
endinterface

// File: rtl/c3po_port_csr.sv
// c3po_port_csr: CTRL / STATUS / COUNT storage for one port.
// Optional feature macro: C3PO_REGS_IRQ_EN (CTRL.irq_mask and irq request).
module c3po_port_csr
  import c3po_regs_pkg::*;
#(
  parameter int PORT_IDX    = 0,
  parameter int CNT_WIDTH_P = 16
) (
  input  logic                       clk,
  input  logic                       reset_L,
  input  logic [NUM_REGS-1:0]        wr_stb,
  input  logic [31:0]                wdata,
  input  logic                       ctrl_err,
  input  logic                       ctrl_idle,
  input  logic                       evt,
  output logic                       enable,
  output logic [3:0]                 port_id,
`ifdef C3PO_REGS_IRQ_EN
  output logic                       irq_req,
`endif
  output logic [NUM_REGS-1:0][31:0]  rd_view
);

  localparam logic [3:0] ID_RST = 4'(PORT_IDX);

  logic                   enable_q, enable_d;
  logic [3:0]             id_q, id_d;
  logic                   sticky_q, sticky_d;
  logic [CNT_WIDTH_P-1:0] cnt_q, cnt_d;
`ifdef C3PO_REGS_IRQ_EN
  logic                   mask_q, mask_d;
`endif
  logic                   unused_wdata;

  // Only a few write-data bits land in storage; the rest are discarded.
  assign unused_wdata = ^wdata;

  // Next-state of every field; the read view is built from next-state so a
  // read launched at a write edge already returns the updated contents.
  always_comb begin
    enable_d = enable_q;
    id_d     = id_q;
`ifdef C3PO_REGS_IRQ_EN
    mask_d   = mask_q;
`endif
    if (wr_stb[CTRL_OFF]) begin
      enable_d = wdata[CTRL_EN_BIT];
      id_d     = wdata[CTRL_ID_LSB +: 4];
`ifdef C3PO_REGS_IRQ_EN
      mask_d   = wdata[CTRL_MASK_BIT];
`endif
    end

    // A new error wins over a simultaneous write-one-to-clear
    sticky_d = (sticky_q & ~(wr_stb[STATUS_OFF] & wdata[STAT_STICKY_BIT])) | ctrl_err;

    cnt_d = cnt_q;
    if (wr_stb[COUNT_OFF]) begin
      cnt_d = '0;
    end else if (evt && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH_P'(1);
    end

    rd_view = '0;
    rd_view[CTRL_OFF][CTRL_EN_BIT]         = enable_d;
    rd_view[CTRL_OFF][CTRL_ID_LSB +: 4]    = id_d;
    rd_view[CTRL_OFF][CTRL_ERR_BIT]        = ctrl_err;
    rd_view[CTRL_OFF][CTRL_IDLE_BIT]       = ctrl_idle;
`ifdef C3PO_REGS_IRQ_EN
    rd_view[CTRL_OFF][CTRL_MASK_BIT]       = mask_d;
`endif
    rd_view[STATUS_OFF][STAT_STICKY_BIT]   = sticky_d;
    rd_view[STATUS_OFF][STAT_IDLE_BIT]     = ctrl_idle;
    rd_view[COUNT_OFF]                     = 32'(cnt_d);
  end

  // Field storage
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      enable_q <= 1'b0;
      id_q     <= ID_RST;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
`ifdef C3PO_REGS_IRQ_EN
      mask_q   <= 1'b0;
`endif
    end else begin
      enable_q <= enable_d;
      id_q     <= id_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
`ifdef C3PO_REGS_IRQ_EN
      mask_q   <= mask_d;
`endif
    end
  end

  assign enable  = enable_q;
  assign port_id = id_q;
`ifdef C3PO_REGS_IRQ_EN
  assign irq_req = sticky_q & mask_q;
`endif

endmodule

// File: rtl/c3po_csr_bank.sv
// c3po_csr_bank: per-port CSR bank behind a registered req/ack host bus.
// Address decode, transaction FSM and response mux live here; per-port
// storage lives in c3po_port_csr.
// Optional feature macro: C3PO_REGS_IRQ_EN (irq output and CTRL.irq_mask).
module c3po_csr_bank
  import c3po_regs_pkg::*;
#(
  parameter int PORTS_P       = 4,
  parameter int ADDR_SIZE_P   = 8,
  parameter int ADDR_OFFSET_P = 16,
  parameter int CNT_WIDTH_P   = 16
) (
  input  logic                    clk,
  input  logic                    reset_L,
  c3po_csr_bank_if.slave          host,
  input  logic [PORTS_P-1:0]      cfg_ctrl_err,
  input  logic [PORTS_P-1:0]      cfg_ctrl_idle,
  input  logic [PORTS_P-1:0]      port_evt,
  output logic [PORTS_P-1:0]      cfg_port_enable,
  output logic [PORTS_P-1:0][3:0] cfg_port_id
`ifdef C3PO_REGS_IRQ_EN
  ,
  output logic                    irq
`endif
);

  state_e                                  state_q, state_d;
  logic [PORTS_P-1:0][NUM_REGS-1:0]        hit;
  logic [PORTS_P-1:0][NUM_REGS-1:0]        wr_stb;
  logic [PORTS_P-1:0][NUM_REGS-1:0][31:0]  view;
  logic                                    mapped;
  logic                                    accept;
  logic                                    ack_q, ack_d;
  logic                                    err_q, err_d;
  logic [31:0]                             rdata_q, rdata_d;

  // Address decode into one-hot per-register hits and write strobes
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < PORTS_P; i++) begin
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        if (32'(host.addr) == 32'(ADDR_OFFSET_P * i + k)) begin
          hit[i][k] = 1'b1;
        end
      end
    end
    mapped = |hit;
    accept = (state_q == ST_IDLE) && host.req;
    wr_stb = (accept && !host.rd_wr) ? hit : '0;
  end

  // Transaction FSM next state and response values
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (host.req) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
          err_d   = !mapped;
          if (host.rd_wr) begin
            for (int unsigned i = 0; i < PORTS_P; i++) begin
              for (int unsigned k = 0; k < NUM_REGS; k++) begin
                if (hit[i][k]) begin
                  rdata_d = rdata_d | view[i][k];
                end
              end
            end
          end
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered response
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign host.ack      = ack_q;
  assign host.resp_err = err_q;
  assign host.read_val = rdata_q;

`ifdef C3PO_REGS_IRQ_EN
  logic [PORTS_P-1:0] irq_req;
  logic               irq_q;

  // Interrupt is the registered OR of masked sticky errors
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |irq_req;
    end
  end

  assign irq = irq_q;
`endif

  for (genvar g = 0; g < PORTS_P; g++) begin : g_port
    c3po_port_csr #(
      .PORT_IDX    (g),
      .CNT_WIDTH_P (CNT_WIDTH_P)
    ) u_port (
      .clk       (clk),
      .reset_L   (reset_L),
      .wr_stb    (wr_stb[g]),
      .wdata     (host.write_val),
      .ctrl_err  (cfg_ctrl_err[g]),
      .ctrl_idle (cfg_ctrl_idle[g]),
      .evt       (port_evt[g]),
      .enable    (cfg_port_enable[g]),
      .port_id   (cfg_port_id[g]),
`ifdef C3PO_REGS_IRQ_EN
      .irq_req   (irq_req[g]),
`endif
      .rd_view   (view[g])
    );
  end

endmodule

// File: tb/tb_c3po_csr_bank.sv
// tb_c3po_csr_bank: directed and randomized checks of c3po_csr_bank against
// an array-based reference model of the register map.
module tb_c3po_csr_bank;
  localparam int PORTS   = 4;
  localparam int OFFS    = 16;
  localparam int CNTW    = 4;
  localparam int CNT_MAX = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            reset_L;
  logic [3:0]      cfg_ctrl_err, cfg_ctrl_idle, port_evt, cfg_port_enable;
  logic [3:0][3:0] cfg_port_id;
`ifdef C3PO_REGS_IRQ_EN
  logic            irq;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  c3po_csr_bank_if #(.ADDR_SIZE_P(8)) bus ();

  c3po_csr_bank #(
    .PORTS_P       (PORTS),
    .ADDR_SIZE_P   (8),
    .ADDR_OFFSET_P (OFFS),
    .CNT_WIDTH_P   (CNTW)
  ) dut (
    .clk             (clk),
    .reset_L         (reset_L),
    .host            (bus),
    .cfg_ctrl_err    (cfg_ctrl_err),
    .cfg_ctrl_idle   (cfg_ctrl_idle),
    .port_evt        (port_evt),
    .cfg_port_enable (cfg_port_enable),
    .cfg_port_id     (cfg_port_id)
`ifdef C3PO_REGS_IRQ_EN
    ,
    .irq             (irq)
`endif
  );

  // ---------------- reference model ----------------
  int   m_en[PORTS], m_id[PORTS], m_mask[PORTS], m_sticky[PORTS], m_cnt[PORTS];
  logic m_busy;
  logic m_acc, m_wr;
  int   m_a, m_p, m_off;

  assign m_acc = bus.req & ~m_busy;
  assign m_a   = int'(bus.addr);
  assign m_p   = m_a / OFFS;
  assign m_off = m_a % OFFS;
  assign m_wr  = m_acc && !bus.rd_wr && (m_a < OFFS * PORTS) && (m_off < 3);

  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      m_busy <= 1'b0;
      for (int q = 0; q < PORTS; q++) begin
        m_en[q] <= 0; m_id[q] <= q; m_mask[q] <= 0; m_sticky[q] <= 0; m_cnt[q] <= 0;
      end
    end else begin
      m_busy <= m_acc;
      for (int q = 0; q < PORTS; q++) begin
        m_sticky[q] <= cfg_ctrl_err[q] ? 1 :
                       ((m_wr && m_p == q && m_off == 1 && bus.write_val[0]) ? 0 : m_sticky[q]);
        m_cnt[q]    <= (m_wr && m_p == q && m_off == 2) ? 0 :
                       ((port_evt[q] && m_cnt[q] < CNT_MAX) ? m_cnt[q] + 1 : m_cnt[q]);
        if (m_wr && m_p == q && m_off == 0) begin
          m_en[q] <= int'(bus.write_val[0]);
          m_id[q] <= int'(bus.write_val[7:4]);
`ifdef C3PO_REGS_IRQ_EN
          m_mask[q] <= int'(bus.write_val[12]);
`endif
        end
      end
    end
  end

  function automatic logic [31:0] model_read(input int a);
    int p, off, v;
    p = a / OFFS;
    off = a % OFFS;
    v = 0;
    if (a >= OFFS * PORTS || off >= 3) return 32'd0;
    case (off)
      0: v = m_en[p] + m_id[p] * 16 + int'(cfg_ctrl_err[p]) * 256 + int'(cfg_ctrl_idle[p]) * 512
             + m_mask[p] * 4096;
      1: v = m_sticky[p] + 2 * int'(cfg_ctrl_idle[p]);
      default: v = m_cnt[p];
    endcase
    return 32'(v);
  endfunction

  function automatic logic [3:0] model_en();
    logic [3:0] r;
    for (int q = 0; q < PORTS; q++) r[q] = (m_en[q] != 0);
    return r;
  endfunction

  function automatic logic [15:0] model_id();
    logic [15:0] r;
    for (int q = 0; q < PORTS; q++) r[q*4 +: 4] = 4'(m_id[q]);
    return r;
  endfunction

  // One host access: req for one edge, sample response in the ack cycle
  task automatic access(input logic rd, input logic [7:0] a, input logic [31:0] wv,
                        output logic [31:0] rv, output logic re, output logic ga);
    @(negedge clk);
    bus.req = 1'b1; bus.rd_wr = rd; bus.addr = a; bus.write_val = wv;
    @(posedge clk);
    @(negedge clk);
    ga = bus.ack; rv = bus.read_val; re = bus.resp_err;
    bus.req = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got=%b exp=0", bus.ack); end
    n_cmp++; if (bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", bus.resp_err); end
    n_cmp++; if (bus.read_val !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", bus.read_val); end
    n_cmp++; if (cfg_port_enable !== 4'h0) begin n_fail++; $display("FAIL reset_en got=%h exp=0", cfg_port_enable); end
    n_cmp++; if (cfg_port_id !== 16'h3210) begin n_fail++; $display("FAIL reset_id got=%h exp=3210", cfg_port_id); end
`ifdef C3PO_REGS_IRQ_EN
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", irq); end
`endif
  endtask

  task automatic test_ctrl_read();
    logic [31:0] rv; logic re, ga;
    access(1'b1, 8'h10, 32'h0, rv, re, ga);
    n_cmp++; if (ga !== 1'b1) begin n_fail++; $display("FAIL rd10_ack got=%b exp=1", ga); end
    n_cmp++; if (rv !== 32'h10) begin n_fail++; $display("FAIL rd10_data got=%h exp=00000010", rv); end
    n_cmp++; if (re !== 1'b0) begin n_fail++; $display("FAIL rd10_err got=%b exp=0", re); end
    n_cmp++; if (cfg_port_id[1] !== 4'd1) begin n_fail++; $display("FAIL id1 got=%h exp=1", cfg_port_id[1]); end
    @(negedge clk);
    n_cmp++; if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL ack_one_cycle got=%b exp=0", bus.ack); end
  endtask

  task automatic test_ctrl_write();
    logic [31:0] rv; logic re, ga;
    access(1'b0, 8'h20, 32'h31, rv, re, ga);
    n_cmp++; if (ga !== 1'b1 || re !== 1'b0) begin n_fail++; $display("FAIL wr20_resp got=%b%b exp=10", ga, re); end
    n_cmp++; if (cfg_port_enable[2] !== 1'b1) begin n_fail++; $display("FAIL en2 got=%b exp=1", cfg_port_enable[2]); end
    n_cmp++; if (cfg_port_id[2] !== 4'd3) begin n_fail++; $display("FAIL id2 got=%h exp=3", cfg_port_id[2]); end
    cfg_ctrl_err[2] = 1'b1; cfg_ctrl_idle[2] = 1'b1;
    access(1'b1, 8'h20, 32'h0, rv, re, ga);
    n_cmp++; if (rv !== 32'h331) begin n_fail++; $display("FAIL rd20_live got=%h exp=00000331", rv); end
    cfg_ctrl_err[2] = 1'b0; cfg_ctrl_idle[2] = 1'b0;
    access(1'b1, 8'h20, 32'h0, rv, re, ga);
    n_cmp++; if (rv !== 32'h31) begin n_fail++; $display("FAIL rd20 got=%h exp=00000031", rv); end
  endtask

  task automatic test_sticky();
    logic [31:0] rv; logic re, ga;
    @(negedge clk); cfg_ctrl_err[0] = 1'b1;
    @(negedge clk); cfg_ctrl_err[0] = 1'b0;
    access(1'b1, 8'h01, 32'h0, rv, re, ga);
    n_cmp++; if (rv !== 32'h1) begin n_fail++; $display("FAIL sticky_set got=%h exp=1", rv); end
    cfg_ctrl_err[0] = 1'b1;
    access(1'b0, 8'h01, 32'h1, rv, re, ga);
    access(1'b1, 8'h01, 32'h0, rv, re, ga);
    n_cmp++; if (rv !== 32'h1) begin n_fail++; $display("FAIL sticky_setwins got=%h exp=1", rv); end
    cfg_ctrl_err[0] = 1'b0;
    access(1'b0, 8'h01, 32'h1, rv, re, ga);
    access(1'b1, 8'h01, 32'h0, rv, re, ga);
    n_cmp++; if (rv !== 32'h0) begin n_fail++; $display("FAIL sticky_w1c got=%h exp=0", rv); end
  endtask

  task automatic test_count();
    logic [31:0] rv; logic re, ga;
    @(negedge clk); port_evt[3] = 1'b1;
    repeat (20) @(negedge clk);
    access(1'b1, 8'h32, 32'h0, rv, re, ga);
    n_cmp++; if (rv !== 32'hF) begin n_fail++; $display("FAIL cnt_sat got=%h exp=f", rv); end
    access(1'b0, 8'h32, 32'hFFFF_FFFF, rv, re, ga);
    port_evt[3] = 1'b0;
    access(1'b1, 8'h32, 32'h0, rv, re, ga);
    n_cmp++; if (rv !== 32'h0) begin n_fail++; $display("FAIL cnt_wrwins got=%h exp=0", rv); end
    port_evt[1] = 1'b1;
    repeat (3) @(negedge clk);
    port_evt[1] = 1'b0;
    access(1'b1, 8'h12, 32'h0, rv, re, ga);
    n_cmp++; if (rv !== 32'h3) begin n_fail++; $display("FAIL cnt_three got=%h exp=3", rv); end
  endtask

  task automatic test_unmapped();
    logic [31:0] rv; logic re, ga;
    access(1'b1, 8'h03, 32'h0, rv, re, ga);
    n_cmp++; if (rv !== 32'h0 || re !== 1'b1 || ga !== 1'b1) begin
      n_fail++; $display("FAIL unm03 got=%h/%b/%b exp=0/1/1", rv, re, ga); end
    access(1'b1, 8'h40, 32'h0, rv, re, ga);
    n_cmp++; if (rv !== 32'h0 || re !== 1'b1) begin n_fail++; $display("FAIL unm40 got=%h/%b exp=0/1", rv, re); end
    access(1'b0, 8'h40, 32'hFFFF_FFFF, rv, re, ga);
    n_cmp++; if (re !== 1'b1) begin n_fail++; $display("FAIL unm40_wr_err got=%b exp=1", re); end
    access(1'b0, 8'h03, 32'hFFFF_FFFF, rv, re, ga);
    n_cmp++; if (cfg_port_enable !== 4'b0100 || cfg_port_id !== 16'h3310) begin
      n_fail++; $display("FAIL unm_nochange got=%h/%h exp=4/3310", cfg_port_enable, cfg_port_id); end
    access(1'b1, 8'h00, 32'h0, rv, re, ga);
    n_cmp++; if (rv !== 32'h0 || re !== 1'b0) begin n_fail++; $display("FAIL ctrl0_intact got=%h/%b exp=0/0", rv, re); end
  endtask

  // req held high across the ack cycle is ignored there, then re-accepted
  task automatic test_back_to_back();
    logic [2:0] acks;
    @(negedge clk);
    bus.req = 1'b1; bus.rd_wr = 1'b1; bus.addr = 8'h10; bus.write_val = 32'h0;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk); @(negedge clk);
      acks[e] = bus.ack;
      if (e == 2) begin
        n_cmp++; if (bus.read_val !== 32'h10) begin n_fail++; $display("FAIL b2b_data got=%h exp=10", bus.read_val); end
        bus.req = 1'b0;
      end
    end
    n_cmp++; if (acks !== 3'b101) begin n_fail++; $display("FAIL b2b_acks got=%b exp=101", acks); end
  endtask

`ifdef C3PO_REGS_IRQ_EN
  task automatic test_irq();
    logic [31:0] rv; logic re, ga;
    access(1'b0, 8'h10, 32'h1011, rv, re, ga);
    @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_idle got=%b exp=0", irq); end
    cfg_ctrl_err[1] = 1'b1;
    @(negedge clk); cfg_ctrl_err[1] = 1'b0;
    @(negedge clk);
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set got=%b exp=1", irq); end
    access(1'b1, 8'h10, 32'h0, rv, re, ga);
    n_cmp++; if (rv !== 32'h1011) begin n_fail++; $display("FAIL irq_ctrl_rd got=%h exp=1011", rv); end
    access(1'b0, 8'h11, 32'h1, rv, re, ga);
    @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear got=%b exp=0", irq); end
  endtask
`endif

  task automatic test_random();
    logic [31:0] rv, exp; logic re, ga, rd; logic [7:0] a; int ai; logic exp_err;
    for (int it = 0; it < 160; it++) begin
      cfg_ctrl_err  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      cfg_ctrl_idle = 4'($urandom);
      port_evt      = 4'($urandom);
      if ($urandom_range(0, 9) < 8) a = 8'($urandom_range(0, 3) * OFFS + $urandom_range(0, 2));
      else                          a = 8'($urandom);
      rd = 1'($urandom_range(0, 1));
      access(rd, a, $urandom, rv, re, ga);
      ai = int'(a);
      exp_err = (ai >= OFFS * PORTS) || (ai % OFFS >= 3);
      n_cmp++; if (ga !== 1'b1) begin n_fail++; $display("FAIL rnd_ack it=%0d got=%b exp=1", it, ga); end
      n_cmp++; if (re !== exp_err) begin n_fail++; $display("FAIL rnd_err it=%0d a=%h got=%b exp=%b", it, a, re, exp_err); end
      if (rd) begin
        exp = model_read(ai);
        n_cmp++; if (rv !== exp) begin n_fail++; $display("FAIL rnd_rd it=%0d a=%h got=%h exp=%h", it, a, rv, exp); end
      end
      n_cmp++; if (cfg_port_enable !== model_en() || cfg_port_id !== model_id()) begin
        n_fail++; $display("FAIL rnd_cfg it=%0d got=%h/%h exp=%h/%h", it, cfg_port_enable, cfg_port_id, model_en(), model_id()); end
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end
    cfg_ctrl_err = '0; cfg_ctrl_idle = '0; port_evt = '0;
  endtask

  task automatic test_reset_mid_ack();
    logic [31:0] rv; logic re, ga;
    @(negedge clk);
    bus.req = 1'b1; bus.rd_wr = 1'b1; bus.addr = 8'h20; bus.write_val = 32'h0;
    @(posedge clk); @(negedge clk);
    n_cmp++; if (bus.ack !== 1'b1) begin n_fail++; $display("FAIL rst_pre_ack got=%b exp=1", bus.ack); end
    bus.req = 1'b0;
    #2 reset_L = 1'b0;
    #1;
    n_cmp++; if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack_drop got=%b exp=0", bus.ack); end
    n_cmp++; if (cfg_port_enable !== 4'h0 || cfg_port_id !== 16'h3210) begin
      n_fail++; $display("FAIL rst_regs got=%h/%h exp=0/3210", cfg_port_enable, cfg_port_id); end
    @(negedge clk); reset_L = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL rst_no_resp got=%b exp=0", bus.ack); end
    access(1'b1, 8'h20, 32'h0, rv, re, ga);
    n_cmp++; if (rv !== 32'h20 || ga !== 1'b1) begin n_fail++; $display("FAIL rst_rd20 got=%h/%b exp=20/1", rv, ga); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_L = 1'b0;
    cfg_ctrl_err = '0; cfg_ctrl_idle = '0; port_evt = '0;
    bus.req = 1'b0; bus.rd_wr = 1'b0; bus.addr = '0; bus.write_val = '0;
    repeat (2) @(negedge clk);
    reset_L = 1'b1;
    test_reset();
    test_ctrl_read();
    test_ctrl_write();
    test_sticky();
    test_count();
    test_unmapped();
    test_back_to_back();
`ifdef C3PO_REGS_IRQ_EN
    test_irq();
`endif
    test_random();
    test_reset_mid_ack();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
